risc_mem_arbiter: RTL and testbench
===================================

# risc_mem_arbiter

Single-port memory arbiter for the non-pipelined RISC core. It shares the unified instruction/data memory between three requesters: instruction fetch, load/store execution, and a debug/program-load port. It issues at most one memory access per cycle and routes each read response back to the requester that issued it. It sits between the core's fetch/execute sequencing and the memory array.

## Interface
Parameters:
- WIDTH, 32, data path width
- ADDRSIZE, 12, memory address width
- MEM_LAT, 1, memory read latency in cycles (legal 1..4)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- if_req / ls_req / dbg_req  in  1 each  access request, held until granted
- if_addr / ls_addr / dbg_addr  in  ADDRSIZE each  access address
- ls_we / dbg_we  in  1 each  1 = write (fetch is read-only)
- ls_wdata / dbg_wdata  in  WIDTH each  write data
- dbg_lock  in  1  when high, only debug may be granted
- if_gnt / ls_gnt / dbg_gnt  out  1 each  one-cycle accept pulse
- if_rvalid / ls_rvalid / dbg_rvalid  out  1 each  read data valid for that requester
- rdata  out  WIDTH  read data, shared, qualified by the rvalid signals
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDRSIZE  memory address
- mem_wdata  out  WIDTH  memory write data
- mem_rdata  in  WIDTH  memory read data, valid MEM_LAT cycles after mem_en with mem_we=0

## Operation
- Each cycle, grant one requester:
  - dbg has fixed top priority.
  - if/ls share round-robin by a 1-bit pointer `last`. `last` = requester granted most recently between if and ls; reset value selects ls as last, so if wins the first tie.
- dbg_lock=1: if_gnt and ls_gnt are forced 0 and their requests wait. No other state changes; `last` is unchanged.
- Grant is combinational from the requests and registered state. mem_en, mem_we, mem_addr and mem_wdata carry the granted requester's signals in the same cycle.
- No grant means mem_en=0 and mem_we=0. mem_addr and mem_wdata are then don't-care, driven 0.
- Owner pipeline: an MEM_LAT-deep shift register of {valid, owner[1:0]}.
  - Loaded on each granted read.
  - At the output end, valid asserts the matching *_rvalid, and rdata = mem_rdata.
- Writes produce no rvalid. gnt is the only completion indication.
- Requesters must hold req, addr, we and wdata stable until gnt. Deasserting req before gnt withdraws the request with no side effects.
- rdata is 0 when no rvalid is asserted.

## Timing
- Grant latency: 0 cycles when uncontended. Reads return data MEM_LAT cycles after gnt, at full throughput (one access per cycle).
- Reset (reset_n low, asynchronous): all gnt=0, all rvalid=0, mem_en=0, mem_we=0, rdata=0, owner pipeline cleared, `last`=ls.
  - Reads in flight during reset are discarded. No rvalid is issued for them after release.
  - First grant is possible in the first cycle after release.
- if and ls both requesting, no dbg: they alternate every cycle.
- dbg requesting every cycle: if and ls starve. This is accepted by design; debug is used only while the core is halted.
- dbg_lock rising with a read in flight: the pending rvalid is still delivered to its owner.
- At most one *_rvalid is high in any cycle.
- At most one *_gnt is high in any cycle.

## Test plan
- Reset then single fetch: if_req=1, if_addr=0x005, MEM[5]=0x4000_1002, MEM_LAT=1 -> if_gnt same cycle, mem_addr=0x005. Next cycle if_rvalid=1, rdata=0x4000_1002.
- if and ls read continuously -> grants alternate if, ls, if, ls starting with if. Each rvalid follows its own gnt by MEM_LAT cycles with correct data, for MEM_LAT=1 and MEM_LAT=3.
- dbg write with if pending: dbg_we=1, dbg_addr=0x010, dbg_wdata=0xDEAD_BEEF, if_req=1 -> dbg_gnt cycle 0 with mem_we=1, if_gnt cycle 1. A later read of 0x010 returns 0xDEAD_BEEF. No dbg_rvalid is issued.
- dbg_lock=1 with if_req and ls_req held for 5 cycles -> no if/ls grant, mem_en=0. Dropping lock yields if_gnt next.
- reset_n pulsed low one cycle after an ls read gnt with MEM_LAT=2 -> outputs go to reset values immediately. No ls_rvalid appears after release.
- Random three-way traffic for 10k cycles against a memory model -> every read returns model data to the correct owner, never two gnt or two rvalid in one cycle.

Source files
------------

// File: rtl/risc_mem_arbiter.sv
// Single-port memory arbiter: debug has fixed priority, fetch and load/store share round-robin.
// Read responses are steered back to the issuing requester through an owner pipeline.
module risc_mem_arbiter #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned ADDRSIZE = 12,
  parameter int unsigned MEM_LAT  = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                if_req,
  input  logic [ADDRSIZE-1:0] if_addr,
  input  logic                ls_req,
  input  logic [ADDRSIZE-1:0] ls_addr,
  input  logic                ls_we,
  input  logic [WIDTH-1:0]    ls_wdata,
  input  logic                dbg_req,
  input  logic [ADDRSIZE-1:0] dbg_addr,
  input  logic                dbg_we,
  input  logic [WIDTH-1:0]    dbg_wdata,
  input  logic                dbg_lock,
  output logic                if_gnt,
  output logic                ls_gnt,
  output logic                dbg_gnt,
  output logic                if_rvalid,
  output logic                ls_rvalid,
  output logic                dbg_rvalid,
  output logic [WIDTH-1:0]    rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDRSIZE-1:0] mem_addr,
  output logic [WIDTH-1:0]    mem_wdata,
  input  logic [WIDTH-1:0]    mem_rdata
);

  typedef enum logic [1:0] {
    OwnIf  = 2'd0,
    OwnLs  = 2'd1,
    OwnDbg = 2'd2
  } owner_e;

  localparam int unsigned SlotW = 3;
  localparam int unsigned PipeW = SlotW * MEM_LAT;

  logic             last_ls_q, last_ls_d;
  logic [PipeW-1:0] pipe_q, pipe_d;
  logic [SlotW-1:0] new_slot;
  logic [SlotW-1:0] out_slot;
  owner_e           rd_owner;
  owner_e           out_owner;
  logic             out_valid;

  // Grant decode; gated by reset_n so nothing is granted while reset is asserted.
  always_comb begin
    if_gnt  = 1'b0;
    ls_gnt  = 1'b0;
    dbg_gnt = 1'b0;
    if (reset_n) begin
      if (dbg_req) begin
        dbg_gnt = 1'b1;
      end else if (!dbg_lock) begin
        if (if_req && ls_req) begin
          if (last_ls_q) begin
            if_gnt = 1'b1;
          end else begin
            ls_gnt = 1'b1;
          end
        end else if (if_req) begin
          if_gnt = 1'b1;
        end else if (ls_req) begin
          ls_gnt = 1'b1;
        end
      end
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    rd_owner  = OwnIf;
    unique case (1'b1)
      dbg_gnt: begin
        mem_en    = 1'b1;
        mem_we    = dbg_we;
        mem_addr  = dbg_addr;
        mem_wdata = dbg_wdata;
        rd_owner  = OwnDbg;
      end
      ls_gnt: begin
        mem_en    = 1'b1;
        mem_we    = ls_we;
        mem_addr  = ls_addr;
        mem_wdata = ls_wdata;
        rd_owner  = OwnLs;
      end
      if_gnt: begin
        mem_en   = 1'b1;
        mem_addr = if_addr;
        rd_owner = OwnIf;
      end
      default: ;
    endcase
  end

  always_comb begin
    last_ls_d = last_ls_q;
    if (if_gnt) begin
      last_ls_d = 1'b0;
    end else if (ls_gnt) begin
      last_ls_d = 1'b1;
    end
  end

  // Slot format is {valid, owner[1:0]}; newest slot enters at the low end.
  assign new_slot = {mem_en & ~mem_we, rd_owner};

  if (MEM_LAT == 1) begin : g_lat1
    assign pipe_d = new_slot;
  end else begin : g_latn
    assign pipe_d = {pipe_q[PipeW-SlotW-1:0], new_slot};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_ls_q <= 1'b1;
      pipe_q    <= '0;
    end else begin
      last_ls_q <= last_ls_d;
      pipe_q    <= pipe_d;
    end
  end

  assign out_slot  = pipe_q[PipeW-1 -: SlotW];
  assign out_valid = out_slot[2];
  assign out_owner = owner_e'(out_slot[1:0]);

  always_comb begin
    if_rvalid  = 1'b0;
    ls_rvalid  = 1'b0;
    dbg_rvalid = 1'b0;
    rdata      = '0;
    if (out_valid) begin
      rdata = mem_rdata;
      unique case (out_owner)
        OwnIf:   if_rvalid  = 1'b1;
        OwnLs:   ls_rvalid  = 1'b1;
        OwnDbg:  dbg_rvalid = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_risc_mem_arbiter.sv
// Directed bench for risc_mem_arbiter: one instance at read latency 1 and one at latency 3,
// sharing requester stimulus, each backed by its own read pipeline over a common memory array.
module tb_risc_mem_arbiter;

  logic        clk;
  logic        reset_n;
  logic        if_req, ls_req, dbg_req, ls_we, dbg_we, dbg_lock;
  logic [11:0] if_addr, ls_addr, dbg_addr;
  logic [31:0] ls_wdata, dbg_wdata;

  logic        if_gnt1, ls_gnt1, dbg_gnt1, if_rv1, ls_rv1, dbg_rv1, men1, mwe1;
  logic [31:0] rdata1, mwdata1, mrdata1;
  logic [11:0] maddr1;
  logic        if_gnt3, ls_gnt3, dbg_gnt3, if_rv3, ls_rv3, dbg_rv3, men3, mwe3;
  logic [31:0] rdata3, mwdata3, mrdata3;
  logic [11:0] maddr3;

  logic [31:0] mem [4096];
  logic [31:0] rp1;
  logic [31:0] rp3 [3];

  int n_cmp;
  int n_err;

  risc_mem_arbiter #(.WIDTH(32), .ADDRSIZE(12), .MEM_LAT(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr),
    .ls_req(ls_req), .ls_addr(ls_addr), .ls_we(ls_we), .ls_wdata(ls_wdata),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_we(dbg_we), .dbg_wdata(dbg_wdata),
    .dbg_lock(dbg_lock),
    .if_gnt(if_gnt1), .ls_gnt(ls_gnt1), .dbg_gnt(dbg_gnt1),
    .if_rvalid(if_rv1), .ls_rvalid(ls_rv1), .dbg_rvalid(dbg_rv1), .rdata(rdata1),
    .mem_en(men1), .mem_we(mwe1), .mem_addr(maddr1), .mem_wdata(mwdata1),
    .mem_rdata(mrdata1)
  );

  risc_mem_arbiter #(.WIDTH(32), .ADDRSIZE(12), .MEM_LAT(3)) u_dut3 (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr),
    .ls_req(ls_req), .ls_addr(ls_addr), .ls_we(ls_we), .ls_wdata(ls_wdata),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_we(dbg_we), .dbg_wdata(dbg_wdata),
    .dbg_lock(dbg_lock),
    .if_gnt(if_gnt3), .ls_gnt(ls_gnt3), .dbg_gnt(dbg_gnt3),
    .if_rvalid(if_rv3), .ls_rvalid(ls_rv3), .dbg_rvalid(dbg_rv3), .rdata(rdata3),
    .mem_en(men3), .mem_we(mwe3), .mem_addr(maddr3), .mem_wdata(mwdata3),
    .mem_rdata(mrdata3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: writes from the latency-1 instance; both instances see identical grants.
  always @(posedge clk) begin
    if (men1 && mwe1) mem[maddr1] <= mwdata1;
    rp1    <= mem[maddr1];
    rp3[0] <= mem[maddr3];
    rp3[1] <= rp3[0];
    rp3[2] <= rp3[1];
  end
  assign mrdata1 = rp1;
  assign mrdata3 = rp3[2];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // At most one grant and one rvalid per instance in any cycle.
  always @(negedge clk) begin
    check("gnt_onehot1", 64'($onehot0({if_gnt1, ls_gnt1, dbg_gnt1})), 64'd1);
    check("rv_onehot1", 64'($onehot0({if_rv1, ls_rv1, dbg_rv1})), 64'd1);
    check("rv_onehot3", 64'($onehot0({if_rv3, ls_rv3, dbg_rv3})), 64'd1);
  end

  initial begin
    logic exp_if, exp_ls;
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < 4096; i++) mem[i] = 32'hA500_0000 + 32'(i);
    mem[5] = 32'h4000_1002;
    reset_n = 1'b0;
    if_req = 1'b1; ls_req = 1'b0; dbg_req = 1'b0; ls_we = 1'b0; dbg_we = 1'b0;
    dbg_lock = 1'b0; if_addr = 12'h005; ls_addr = '0; dbg_addr = '0;
    ls_wdata = '0; dbg_wdata = '0;

    // Reset state with a fetch request already pending
    #3;
    check("rst_if_gnt", 64'(if_gnt1), 64'd0);
    check("rst_mem_en", 64'(men1), 64'd0);
    check("rst_mem_we", 64'(mwe1), 64'd0);
    check("rst_rvalid", 64'({if_rv1, ls_rv1, dbg_rv1}), 64'd0);
    check("rst_rdata", 64'(rdata1), 64'd0);

    // Single fetch, first cycle after release
    @(posedge clk); #1;
    reset_n = 1'b1;
    #1;
    check("t1_if_gnt", 64'(if_gnt1), 64'd1);
    check("t1_mem_en", 64'(men1), 64'd1);
    check("t1_mem_addr", 64'(maddr1), 64'h005);
    check("t1_others", 64'({ls_gnt1, dbg_gnt1, mwe1}), 64'd0);
    tick();
    if_req = 1'b0;
    #1;
    check("t1_if_rvalid1", 64'(if_rv1), 64'd1);
    check("t1_rdata1", 64'(rdata1), 64'h4000_1002);
    check("t1_if_rvalid3_early", 64'(if_rv3), 64'd0);
    tick();
    #1;
    check("t1_rvalid1_gone", 64'(if_rv1), 64'd0);
    check("t1_rdata1_zero", 64'(rdata1), 64'd0);
    tick();
    #1;
    check("t1_if_rvalid3", 64'(if_rv3), 64'd1);
    check("t1_rdata3", 64'(rdata3), 64'h4000_1002);

    // Re-reset so the round-robin pointer starts from its reset value
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;

    // Continuous if/ls reads alternate starting with if
    if_req = 1'b1; if_addr = 12'h020;
    ls_req = 1'b1; ls_addr = 12'h030;
    for (int k = 0; k < 8; k++) begin
      #1;
      check("t2_if_gnt", 64'(if_gnt1), 64'((k % 2) == 0));
      check("t2_ls_gnt", 64'(ls_gnt1), 64'((k % 2) == 1));
      exp_if = (k >= 1) && (((k - 1) % 2) == 0);
      exp_ls = (k >= 1) && (((k - 1) % 2) == 1);
      check("t2_if_rv1", 64'(if_rv1), 64'(exp_if));
      check("t2_ls_rv1", 64'(ls_rv1), 64'(exp_ls));
      check("t2_rdata1", 64'(rdata1),
            exp_if ? 64'hA500_0020 : (exp_ls ? 64'hA500_0030 : 64'd0));
      exp_if = (k >= 3) && (((k - 3) % 2) == 0);
      exp_ls = (k >= 3) && (((k - 3) % 2) == 1);
      check("t2_if_rv3", 64'(if_rv3), 64'(exp_if));
      check("t2_ls_rv3", 64'(ls_rv3), 64'(exp_ls));
      check("t2_rdata3", 64'(rdata3),
            exp_if ? 64'hA500_0020 : (exp_ls ? 64'hA500_0030 : 64'd0));
      tick();
    end
    if_req = 1'b0; ls_req = 1'b0;
    tick(); tick(); tick();

    // Debug write beats a pending fetch; read back through debug
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 12'h010; dbg_wdata = 32'hDEAD_BEEF;
    if_req = 1'b1; if_addr = 12'h005;
    #1;
    check("t3_dbg_gnt", 64'(dbg_gnt1), 64'd1);
    check("t3_if_wait", 64'(if_gnt1), 64'd0);
    check("t3_mem_we", 64'(mwe1), 64'd1);
    check("t3_mem_addr", 64'(maddr1), 64'h010);
    check("t3_mem_wdata", 64'(mwdata1), 64'hDEAD_BEEF);
    tick();
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_wdata = '0;
    #1;
    check("t3_if_gnt", 64'(if_gnt1), 64'd1);
    check("t3_no_dbg_rv", 64'(dbg_rv1), 64'd0);
    tick();
    if_req = 1'b0;
    dbg_req = 1'b1;
    #1;
    check("t3_dbg_rd_gnt", 64'(dbg_gnt1), 64'd1);
    check("t3_if_rv1", 64'(if_rv1), 64'd1);
    check("t3_if_rdata1", 64'(rdata1), 64'h4000_1002);
    tick();
    dbg_req = 1'b0;
    #1;
    check("t3_dbg_rv1", 64'(dbg_rv1), 64'd1);
    check("t3_dbg_rdata1", 64'(rdata1), 64'hDEAD_BEEF);
    tick();
    tick();
    #1;
    check("t3_dbg_rv3", 64'(dbg_rv3), 64'd1);
    check("t3_dbg_rdata3", 64'(rdata3), 64'hDEAD_BEEF);
    tick();

    // ls read in flight, then lock with if and ls both waiting
    ls_req = 1'b1; ls_addr = 12'h030;
    #1;
    check("t4_ls_gnt", 64'(ls_gnt1), 64'd1);
    tick();
    if_req = 1'b1; if_addr = 12'h020;
    dbg_lock = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("t4_lock_gnt", 64'({if_gnt1, ls_gnt1, dbg_gnt1}), 64'd0);
      check("t4_lock_mem_en", 64'(men1), 64'd0);
      check("t4_ls_rv1", 64'(ls_rv1), 64'(k == 0));
      check("t4_ls_rv3", 64'(ls_rv3), 64'(k == 2));
      check("t4_rdata3", 64'(rdata3), (k == 2) ? 64'hA500_0030 : 64'd0);
      tick();
    end
    dbg_lock = 1'b0;
    #1;
    check("t4_unlock_if", 64'(if_gnt1), 64'd1);
    check("t4_unlock_ls", 64'(ls_gnt1), 64'd0);
    tick();
    if_req = 1'b0;
    #1;
    check("t4_then_ls", 64'(ls_gnt1), 64'd1);
    tick();
    ls_req = 1'b0;
    tick(); tick(); tick();

    // Reset one cycle after an ls read grant discards the read
    ls_req = 1'b1; ls_addr = 12'h030;
    #1;
    check("t5_ls_gnt", 64'(ls_gnt1), 64'd1);
    tick();
    ls_req = 1'b0;
    if_req = 1'b1; if_addr = 12'h005;
    #1;
    reset_n = 1'b0;
    #1;
    check("t5_rst_ls_rv1", 64'(ls_rv1), 64'd0);
    check("t5_rst_rdata1", 64'(rdata1), 64'd0);
    check("t5_rst_gnt", 64'({if_gnt1, if_gnt3}), 64'd0);
    check("t5_rst_mem_en", 64'({men1, men3}), 64'd0);
    tick();
    reset_n = 1'b1;
    #1;
    check("t5_first_gnt", 64'(if_gnt3), 64'd1);
    tick();
    if_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("t5_no_ls_rv3", 64'(ls_rv3), 64'd0);
      check("t5_no_ls_rv1", 64'(ls_rv1), 64'd0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
